s7_display_ctrl: RTL

Next-generation multiplexed 7-segment display controller for N digits. It combines scan timing, BCD/hex decode, tear-free data loading, PWM brightness, per-digit blink, leading-zero blanking and decimal points in one block. Output polarity is configurable for common-anode or common-cathode boards. It sits between the datapath that produces the BCD value and the board's segment and digit-select pins.

---
 rtl/s7_display_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/s7_display_ctrl.sv
// Multiplexed N-digit 7-segment controller: scan, hex decode, frame-synchronous
// data commit, PWM brightness, blink, leading-zero blanking and output polarity.
module s7_display_ctrl #(
  parameter int DIS_NUM     = 4,
  parameter int MLT_CNT     = 10,
  parameter int BRIGHT_W    = 3,
  parameter int BLINK_CNT   = 5000000,
  parameter int HEX_EN      = 1,
  parameter int SEG_ACT_LOW = 0,
  parameter int SEL_ACT_LOW = 0
) (
  input  logic                  clk_i,
  input  logic                  i_rst_n,
  input  logic [DIS_NUM*4-1:0]  i_bcd_data,
  input  logic [DIS_NUM-1:0]    i_dp,
  input  logic                  i_load,
  input  logic [DIS_NUM-1:0]    i_blink,
  input  logic                  i_lzb,
  input  logic [BRIGHT_W-1:0]   i_bright,
  input  logic                  i_en,
  output logic [6:0]            o_segments,
  output logic                  o_dp,
  output logic [DIS_NUM-1:0]    o_segments_sel,
  output logic                  o_busy
);

  localparam int PRESC_W = $clog2(MLT_CNT);
  localparam int IDX_W   = (DIS_NUM > 1) ? $clog2(DIS_NUM) : 1;
  localparam int BLINK_W = $clog2(BLINK_CNT);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(MLT_CNT - 1);
  localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(DIS_NUM - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_CNT - 1);
  localparam logic SEG_OFF = (SEG_ACT_LOW != 0);
  localparam logic SEL_OFF = (SEL_ACT_LOW != 0);

  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [BRIGHT_W-1:0]  pwm_q, pwm_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 blink_on_q, blink_on_d;
  logic [DIS_NUM*4-1:0] pend_data_q, pend_data_d, disp_data_q, disp_data_d;
  logic [DIS_NUM-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic                 busy_q, busy_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic [DIS_NUM-1:0]   sel_q, sel_d;

  logic                 presc_wrap, frame_end, sel_on, blink_hide;
  logic [3:0]           cur_code;
  logic [6:0]           seg_raw;
  logic                 dp_raw;
  logic [DIS_NUM-1:0]   sel_raw;
  logic [DIS_NUM:1]     zero_hi;
  logic [DIS_NUM-1:0]   blank;

  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'h0: decode = 7'h3F;
      4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;
      4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;
      4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;
      4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h6F;
      4'hA: decode = (HEX_EN != 0) ? 7'h77 : 7'h00;
      4'hB: decode = (HEX_EN != 0) ? 7'h7C : 7'h00;
      4'hC: decode = (HEX_EN != 0) ? 7'h39 : 7'h00;
      4'hD: decode = (HEX_EN != 0) ? 7'h5E : 7'h00;
      4'hE: decode = (HEX_EN != 0) ? 7'h79 : 7'h00;
      default: decode = (HEX_EN != 0) ? 7'h71 : 7'h00;
    endcase
  endfunction

  // zero_hi[k]: digit k and every digit above it are zero.
  assign zero_hi[DIS_NUM] = 1'b1;
  assign blank[0]         = 1'b0;
  generate
    for (genvar gi = 1; gi < DIS_NUM; gi++) begin : g_lzb
      assign zero_hi[gi] = zero_hi[gi+1] && (disp_data_q[4*gi +: 4] == 4'h0);
      assign blank[gi]   = i_lzb && zero_hi[gi];
    end
  endgenerate

  always_comb begin
    presc_wrap  = (presc_q == PRESC_MAX);
    frame_end   = presc_wrap && (idx_q == IDX_MAX);
    presc_d     = presc_wrap ? '0 : presc_q + 1'b1;
    idx_d       = idx_q;
    if (presc_wrap) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    pwm_d       = pwm_q + 1'b1;
    blink_cnt_d = (blink_cnt_q == BLINK_MAX) ? '0 : blink_cnt_q + 1'b1;
    blink_on_d  = (blink_cnt_q == BLINK_MAX) ? ~blink_on_q : blink_on_q;

    // A load in the boundary cycle wins over the commit and defers it a frame.
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    disp_data_d = disp_data_q;
    disp_dp_d   = disp_dp_q;
    busy_d      = busy_q;
    if (i_load) begin
      pend_data_d = i_bcd_data;
      pend_dp_d   = i_dp;
      busy_d      = 1'b1;
    end else if (frame_end && busy_q) begin
      disp_data_d = pend_data_q;
      disp_dp_d   = pend_dp_q;
      busy_d      = 1'b0;
    end

    cur_code   = disp_data_q[4*idx_q +: 4];
    sel_on     = i_en && (pwm_q <= i_bright);
    blink_hide = !blink_on_q && i_blink[idx_q];
    seg_raw    = (sel_on && !blink_hide && !blank[idx_q]) ? decode(cur_code) : 7'h00;
    dp_raw     = sel_on && !blink_hide && disp_dp_q[idx_q];
    sel_raw    = sel_on ? (DIS_NUM'(1) << idx_q) : '0;

    seg_d = SEG_OFF ? ~seg_raw : seg_raw;
    dp_d  = SEG_OFF ? ~dp_raw  : dp_raw;
    sel_d = SEL_OFF ? ~sel_raw : sel_raw;
  end

  always_ff @(posedge clk_i or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q     <= '0;
      idx_q       <= '0;
      pwm_q       <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      disp_data_q <= '0;
      disp_dp_q   <= '0;
      busy_q      <= 1'b0;
      seg_q       <= {7{SEG_OFF}};
      dp_q        <= SEG_OFF;
      sel_q       <= {DIS_NUM{SEL_OFF}};
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      pwm_q       <= pwm_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      disp_data_q <= disp_data_d;
      disp_dp_q   <= disp_dp_d;
      busy_q      <= busy_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      sel_q       <= sel_d;
    end
  end

  assign o_segments     = seg_q;
  assign o_dp           = dp_q;
  assign o_segments_sel = sel_q;
  assign o_busy         = busy_q;

endmodule
